// File: rtl/operand_entry_if.sv
// Operand-entry bus: raw board inputs towards the front end, conditioned
// operands and status back to the calculator input register.
interface operand_entry_if #(
    parameter int N = 16
);
    logic [N-1:0] sw_in;
    logic         btn_load_in;
    logic         btn_mode_in;
    logic         btn_clr_in;
    logic [1:0]   btn_chg_in;

    logic [N-1:0] Z_out;
    logic [N-1:0] Y_out;
    logic [1:0]   mode_out;
    logic [1:0]   btn_change_out;
    logic [1:0]   state_out;
    logic         ready_out;

    modport master (
        output sw_in, btn_load_in, btn_mode_in, btn_clr_in, btn_chg_in,
        input  Z_out, Y_out, mode_out, btn_change_out, state_out, ready_out
    );

    modport slave (
        input  sw_in, btn_load_in, btn_mode_in, btn_clr_in, btn_chg_in,
        output Z_out, Y_out, mode_out, btn_change_out, state_out, ready_out
    );
endinterface

// File: rtl/operand_entry.sv
// Button conditioning and Z-then-Y operand entry for the calculator datapath.
// Define OPERAND_ENTRY_DEBOUNCE_EN to insert a DB_CYCLES debounce after the synchronizers.
module operand_entry #(
    parameter int N         = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    operand_entry_if.slave   bus
);
    localparam int unsigned NB = 5;

    typedef enum logic [1:0] {
        S_Z     = 2'b00,
        S_Y     = 2'b01,
        S_READY = 2'b10
    } state_t;

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("DB_CYCLES must be at least 1");
    end

    // Bit order: {chg[1], chg[0], clr, mode, load}
    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_s1;
    logic [NB-1:0] r_s2;
    logic [NB-1:0] w_filt;
    logic [NB-1:0] r_filt_d;
    logic [NB-1:0] w_press;

    logic          w_load;
    logic          w_mode;
    logic          w_clr;
    logic [1:0]    w_chg;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_z;
    logic [N-1:0]  r_y;
    logic [N-1:0]  w_z_nxt;
    logic [N-1:0]  w_y_nxt;
    logic [1:0]    r_mode;
    logic [1:0]    r_chg;
    logic          r_ready;

    assign w_raw = {bus.btn_chg_in, bus.btn_clr_in, bus.btn_mode_in, bus.btn_load_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_filt_d <= '0;
        end else begin
            r_s1     <= w_raw;
            r_s2     <= r_s1;
            r_filt_d <= w_filt;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] r_cnt [NB];
    logic [NB-1:0] r_filt;

    // Filtered level follows s2 only after DB_CYCLES consecutive disagreeing edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_s2[i] != r_filt[i]) begin
                    if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
                        r_filt[i] <= r_s2[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_s2;
`endif

    assign w_press = w_filt & ~r_filt_d;
    assign w_load  = w_press[0];
    assign w_mode  = w_press[1];
    assign w_clr   = w_press[2];
    assign w_chg   = w_press[4:3];

    always_comb begin
        w_state_nxt = r_state;
        w_z_nxt     = r_z;
        w_y_nxt     = r_y;
        case (r_state)
            S_Z: begin
                if (w_load) begin
                    w_z_nxt     = bus.sw_in;
                    w_state_nxt = S_Y;
                end
            end
            S_Y: begin
                if (w_load) begin
                    w_y_nxt     = bus.sw_in;
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (w_load) begin
                    w_z_nxt     = bus.sw_in;
                    w_state_nxt = S_Y;
                end
            end
            default: begin
                w_state_nxt = S_Z;
                w_z_nxt     = '0;
                w_y_nxt     = '0;
            end
        endcase
        // Clear overrides whatever the load decode produced above.
        if (w_clr) begin
            w_state_nxt = S_Z;
            w_z_nxt     = '0;
            w_y_nxt     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_Z;
            r_z     <= '0;
            r_y     <= '0;
            r_mode  <= '0;
            r_chg   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_z     <= w_z_nxt;
            r_y     <= w_y_nxt;
            r_ready <= (w_state_nxt == S_READY);
            r_chg   <= r_chg ^ w_chg;
            if (w_mode) begin
                r_mode <= r_mode + 2'd1;
            end
        end
    end

    assign bus.Z_out          = r_z;
    assign bus.Y_out          = r_y;
    assign bus.mode_out       = r_mode;
    assign bus.btn_change_out = r_chg;
    assign bus.state_out      = r_state;
    assign bus.ready_out      = r_ready;
endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a behavioural model pushes expected
// output snapshots, which are popped and compared once the press has settled.
module tb_operand_entry;
    localparam int N  = 16;
    localparam int DB = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif
    localparam int HOLD = LAT;

    localparam logic [4:0] B_LOAD = 5'b00001;
    localparam logic [4:0] B_MODE = 5'b00010;
    localparam logic [4:0] B_CLR  = 5'b00100;
    localparam logic [4:0] B_CHG0 = 5'b01000;
    localparam logic [4:0] B_CHG1 = 5'b10000;

    typedef struct packed {
        logic [N-1:0] z;
        logic [N-1:0] y;
        logic [1:0]   mode;
        logic [1:0]   chg;
        logic [1:0]   state;
        logic         ready;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_entry_if #(.N(N)) bus ();

    operand_entry #(.N(N), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    snap_t        q[$];
    snap_t        exp_s;
    snap_t        act_s;
    int           total = 0;
    int           bad   = 0;

    logic [N-1:0] m_z;
    logic [N-1:0] m_y;
    logic [1:0]   m_mode;
    logic [1:0]   m_chg;
    logic [1:0]   m_state;

    function automatic snap_t sample();
        snap_t s;
        s.z     = bus.Z_out;
        s.y     = bus.Y_out;
        s.mode  = bus.mode_out;
        s.chg   = bus.btn_change_out;
        s.state = bus.state_out;
        s.ready = bus.ready_out;
        return s;
    endfunction

    function automatic void push_model();
        snap_t s;
        s.z     = m_z;
        s.y     = m_y;
        s.mode  = m_mode;
        s.chg   = m_chg;
        s.state = m_state;
        s.ready = (m_state == 2'b10);
        q.push_back(s);
    endfunction

    function automatic void mdl_reset();
        m_z = '0; m_y = '0; m_mode = '0; m_chg = '0; m_state = 2'b00;
    endfunction

    function automatic void mdl_load(input logic [N-1:0] sw);
        case (m_state)
            2'b00:   begin m_z = sw; m_state = 2'b01; end
            2'b01:   begin m_y = sw; m_state = 2'b10; end
            default: begin m_z = sw; m_state = 2'b01; end
        endcase
    endfunction

    function automatic void mdl_clear();
        m_z = '0; m_y = '0; m_state = 2'b00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] mask);
        {bus.btn_chg_in, bus.btn_clr_in, bus.btn_mode_in, bus.btn_load_in} = mask;
    endtask

    task automatic drive_press(input logic [4:0] mask, input logic [N-1:0] sw, input int hold);
        bus.sw_in = sw;
        set_btns(mask);
        tick(hold);
        set_btns('0);
        tick(LAT + 2);
    endtask

    task automatic test_reset();
        bus.sw_in = '0;
        set_btns('0);
        rst = 1'b0;
        tick(3);
        mdl_reset();
        push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL reset_hold act=%h exp=%h", act_s, exp_s); end
        rst = 1'b1;
        tick(3);
        push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL after_reset act=%h exp=%h", act_s, exp_s); end
    endtask

    task automatic test_load_sequence();
        drive_press(B_LOAD, 16'h0012, HOLD);
        mdl_load(16'h0012); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL load_z act=%h exp=%h", act_s, exp_s); end

        drive_press(B_LOAD, 16'h0034, HOLD);
        mdl_load(16'h0034); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL load_y act=%h exp=%h", act_s, exp_s); end

        drive_press(B_LOAD, 16'hFFFF, HOLD);
        mdl_load(16'hFFFF); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL reload_z act=%h exp=%h", act_s, exp_s); end
    endtask

    task automatic test_mode();
        for (int i = 0; i < 5; i++) begin
            drive_press(B_MODE, 16'h0000, HOLD);
            m_mode = m_mode + 2'd1;
            push_model();
            exp_s = q.pop_front(); act_s = sample(); total++;
            if (act_s !== exp_s) begin bad++; $display("FAIL mode_step%0d act=%h exp=%h", i, act_s, exp_s); end
        end
        drive_press(B_CLR, 16'h0000, HOLD);
        mdl_clear(); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL clear_keeps_mode act=%h exp=%h", act_s, exp_s); end
    endtask

    task automatic test_load_clear_same();
        drive_press(B_LOAD, 16'h00AB, HOLD);
        mdl_load(16'h00AB); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL pre_load act=%h exp=%h", act_s, exp_s); end

        drive_press(B_LOAD | B_CLR, 16'h5555, HOLD);
        mdl_clear(); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL load_clr act=%h exp=%h", act_s, exp_s); end
    endtask

    task automatic test_chg();
        drive_press(B_CHG0 | B_CHG1, 16'h0000, HOLD);
        m_chg = m_chg ^ 2'b11; push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL chg_both act=%h exp=%h", act_s, exp_s); end

        drive_press(B_CHG0, 16'h0000, HOLD);
        m_chg = m_chg ^ 2'b01; push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL chg_bit0 act=%h exp=%h", act_s, exp_s); end
    endtask

    task automatic test_latency();
        push_model();
        bus.sw_in = 16'h1234;
        set_btns(B_LOAD);
        tick(LAT);
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL lat_early act=%h exp=%h", act_s, exp_s); end
        mdl_load(16'h1234); push_model();
        tick(1);
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL lat_edge act=%h exp=%h", act_s, exp_s); end
        tick(10 - LAT - 1);
        set_btns('0);
        tick(LAT + 2);
        push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL lat_single act=%h exp=%h", act_s, exp_s); end
    endtask

    task automatic test_glitch();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
        drive_press(B_LOAD, 16'hBEEF, 3);
        push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL glitch_ignored act=%h exp=%h", act_s, exp_s); end
`else
        drive_press(B_LOAD, 16'hBEEF, 1);
        mdl_load(16'hBEEF); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL short_pulse act=%h exp=%h", act_s, exp_s); end
`endif
    endtask

    task automatic test_reset_mid();
        set_btns(B_CHG0);
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        mdl_reset(); push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL async_reset act=%h exp=%h", act_s, exp_s); end
        tick(3);
        rst = 1'b1;
        tick(LAT + 4);
        set_btns('0);
        tick(LAT + 2);
        m_chg = 2'b01; push_model();
        exp_s = q.pop_front(); act_s = sample(); total++;
        if (act_s !== exp_s) begin bad++; $display("FAIL reset_held_toggle act=%h exp=%h", act_s, exp_s); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_sequence();
        test_mode();
        test_load_clear_same();
        test_chg();
        test_latency();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end input stage feeding the registered calculator datapath. Conditions the board's raw switch and push-button inputs, then sequences operand entry (Z, then Y) with a small state machine. Produces the stable `Z`, `Y`, `mode` and `btn_change` values that the calculator's input register samples every cycle. All outputs are registered and change only on `clk` rising edges.

## Interface
- `N`, 16: operand width, matching the calculator datapath.
- `DB_CYCLES`, 4: debounce stability window in clock cycles. Must be ≥1; the board build sets it to 500000.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `sw_in`  in  N: operand switches, sampled when a load press is accepted.
- `btn_load_in`  in  1: raw load button, active-high.
- `btn_mode_in`  in  1: raw mode-step button, active-high.
- `btn_clr_in`  in  1: raw clear button, active-high.
- `btn_chg_in`  in  2: raw display-select buttons, active-high.
- `Z_out`  out  N: operand Z.
- `Y_out`  out  N: operand Y.
- `mode_out`  out  2: operation select.
- `btn_change_out`  out  2: display-select toggles.
- `state_out`  out  2: FSM state encoding.
- `ready_out`  out  1: high only when both operands are loaded (S_READY).

## Operation
- Every raw button passes through a 2-FF synchronizer (s1, s2).
- The filtered level `filt` equals s2, or the debounced s2 when debounce is compiled in (see Configuration).
- A press is a one-cycle pulse, `filt & ~filt_d`. Release produces nothing. A held button yields exactly one press.
- FSM states:
  - S_Z = 2'b00: waiting for Z.
  - S_Y = 2'b01: waiting for Y.
  - S_READY = 2'b10: both operands loaded.
  - 2'b11 is illegal; it recovers to S_Z at the next edge with `Z_out`/`Y_out` cleared.
- Transitions on a load press:
  - S_Z: `Z_out` ← `sw_in`, go to S_Y.
  - S_Y: `Y_out` ← `sw_in`, go to S_READY.
  - S_READY: `Z_out` ← `sw_in`, `Y_out` held, go to S_Y.
- Clear press, from any state: go to S_Z and set `Z_out` = `Y_out` = 0. Clear has priority over a simultaneous load; that load is discarded.
- Mode press: `mode_out` increments modulo 4 (3→0). This is independent of FSM state and unaffected by clear.
- `btn_chg_in[i]` press: `btn_change_out[i]` toggles. Both bits may toggle in the same cycle. Unaffected by clear.
- Simultaneous load and mode presses: both take effect in the same cycle.
- `ready_out` = (state == S_READY), driven by a register.

## Timing
- Reset (`rst` low, asynchronous) forces the following; all outputs stay at these values until the first accepted press:
  - `Z_out` = 0, `Y_out` = 0, `mode_out` = 0, `btn_change_out` = 0.
  - `state_out` = S_Z, `ready_out` = 0.
  - Synchronizers, `filt`, `filt_d` and debounce counters all cleared.
- A button held high through reset deassertion counts as one press after release.
- Raw rise first captured by s1 at edge k:
  - Debounce off: outputs update at edge k+2.
  - Debounce on: outputs update at edge k+2+DB_CYCLES.
- Reset asserted mid-debounce or mid-entry discards all progress; there is no partial operand.
- No handshake with downstream. The consumer samples every cycle, and the values are stable between presses.

## Configuration
- Macro `OPERAND_ENTRY_DEBOUNCE_EN`.
- Defined:
  - Each button has a counter of width $clog2(DB_CYCLES+1).
  - The counter increments each cycle that s2 ≠ `filt` and clears whenever they agree.
  - `filt` flips, and the counter clears, at the edge where the mismatch has persisted for DB_CYCLES consecutive sampled edges.
  - A glitch shorter than DB_CYCLES cycles produces no press.
- Undefined: `filt` = s2 and there are no counters. Every synchronized rising edge is a press.

## Test plan
- Reset, then load press with `sw_in`=16'h0012, then another load press with `sw_in`=16'h0034: `Z_out`=0x0012, `Y_out`=0x0034, `state_out`=2'b10, `ready_out`=1.
- From S_READY, load press with `sw_in`=16'hFFFF: `Z_out`=0xFFFF, `Y_out` stays 0x0034, state = S_Y, `ready_out`=0.
- Five mode presses from reset: `mode_out` sequence 1, 2, 3, 0, 1. Clear press afterwards leaves `mode_out`=1.
- Load and clear asserted on the same cycle while in S_Y: state = S_Z, `Z_out`=`Y_out`=0, no operand captured.
- With the macro defined and DB_CYCLES=4:
  - 3-cycle pulse on `btn_load_in`: no state change.
  - 10-cycle hold: exactly one press, with the update at edge k+6.
- `rst` pulsed low mid-debounce with `btn_chg_in`=2'b01 held: all outputs 0 immediately. After release, exactly one toggle gives `btn_change_out`=2'b01.
